// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding definitions: opcodes, class codes, NOP word and encoder FSM states.
// Defining INSTR_ENC_NOP_PAD_EN adds the PAD state, which writes a NOP after each B/JAL/JALR word.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Immediate bits live in instr[31:7]; the packer returns exactly that slice.
  localparam int IMM_BITS_W = 25;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_B    = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_JALR = 3'd6,
    CLS_LUI  = 3'd7
  } cls_e;

`ifdef INSTR_ENC_NOP_PAD_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENC  = 3'd1,
    ST_WR   = 3'd2,
    ST_FULL = 3'd3,
    ST_PAD  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENC  = 3'd1,
    ST_WR   = 3'd2,
    ST_FULL = 3'd3
  } state_e;
`endif

  function automatic logic [6:0] opcode_of(input cls_e cls);
    case (cls)
      CLS_R:    opcode_of = OPC_R;
      CLS_I:    opcode_of = OPC_I;
      CLS_LW:   opcode_of = OPC_LW;
      CLS_SW:   opcode_of = OPC_SW;
      CLS_B:    opcode_of = OPC_B;
      CLS_JAL:  opcode_of = OPC_JAL;
      CLS_JALR: opcode_of = OPC_JALR;
      CLS_LUI:  opcode_of = OPC_LUI;
    endcase
  endfunction

  function automatic logic uses_rd(input cls_e cls);
    uses_rd = !(cls == CLS_SW || cls == CLS_B);
  endfunction

  function automatic logic uses_rs1(input cls_e cls);
    uses_rs1 = !(cls == CLS_JAL || cls == CLS_LUI);
  endfunction

  function automatic logic uses_rs2(input cls_e cls);
    uses_rs2 = (cls == CLS_R || cls == CLS_SW || cls == CLS_B);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational immediate scatter: places the class's immediate into instr[31:7]
// (register fields left zero) and flags whether the immediate is encodable.
module instr_encoder_imm_packer
  import instr_encoder_pkg::*;
(
  input  cls_e                  i_cls,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_imm,
  output logic [IMM_BITS_W-1:0] o_imm_bits,
  output logic                  o_range_ok
);

  logic w_fits12;
  logic w_fits13;
  logic w_fits21;
  logic w_is_shift;

  // A value fits N signed bits when everything above bit N-2 is a pure sign extension.
  assign w_fits12   = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_fits13   = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_fits21   = (&i_imm[31:20]) | ~(|i_imm[31:20]);
  assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

  // Bit k of o_imm_bits is instruction bit k+7.
  always_comb begin
    o_imm_bits = '0;
    o_range_ok = 1'b1;
    case (i_cls)
      CLS_R: begin
        o_range_ok = 1'b1;
      end
      CLS_I: begin
        if (w_is_shift) begin
          o_imm_bits[17:13] = i_imm[4:0];
          o_range_ok        = ~(|i_imm[31:5]);
        end else begin
          o_imm_bits[24:13] = i_imm[11:0];
          o_range_ok        = w_fits12;
        end
      end
      CLS_LW, CLS_JALR: begin
        o_imm_bits[24:13] = i_imm[11:0];
        o_range_ok        = w_fits12;
      end
      CLS_SW: begin
        o_imm_bits[24:18] = i_imm[11:5];
        o_imm_bits[4:0]   = i_imm[4:0];
        o_range_ok        = w_fits12;
      end
      CLS_B: begin
        o_imm_bits[24]    = i_imm[12];
        o_imm_bits[23:18] = i_imm[10:5];
        o_imm_bits[4:1]   = i_imm[4:1];
        o_imm_bits[0]     = i_imm[11];
        o_range_ok        = w_fits13 & ~i_imm[0];
      end
      CLS_JAL: begin
        o_imm_bits[24]    = i_imm[20];
        o_imm_bits[23:14] = i_imm[10:1];
        o_imm_bits[13]    = i_imm[11];
        o_imm_bits[12:5]  = i_imm[19:12];
        o_range_ok        = w_fits21 & ~i_imm[0];
      end
      CLS_LUI: begin
        o_imm_bits[24:5] = i_imm[31:12];
        o_range_ok       = ~(|i_imm[11:0]);
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I field bundles into instruction words and writes them sequentially to imem.
// Optional INSTR_ENC_NOP_PAD_EN: a NOP is written after every B/JAL/JALR word.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W     = 6,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output state_e            dbg_state
);

  localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e                  r_state;
  state_e                  w_next;
  logic                    r_rst_done;
  cls_e                    r_cls;
  logic [2:0]              r_funct3;
  logic                    r_funct7b5;
  logic [4:0]              r_rd;
  logic [4:0]              r_rs1;
  logic [4:0]              r_rs2;
  logic [31:0]             r_imm;
  logic [31:0]             r_word;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W:0]         r_count;
  logic                    r_err;

  logic                    w_full;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_wr_state;
  logic [ADDR_W:0]         w_count_inc;
  logic                    w_last_word;
  logic [IMM_BITS_W-1:0]   w_imm_bits;
  logic                    w_range_ok;
  logic [31:0]             w_enc_word;

  // Handshake: a bundle transfers on a rising edge where in_valid && in_ready; in_ready
  // depends only on FSM state, fill level and clear, never on in_valid.
  assign w_full      = (r_count == DEPTH);
  assign w_ready     = (r_state == ST_IDLE) && !w_full && r_rst_done && !clear;
  assign w_accept    = in_valid && w_ready;
  assign w_count_inc = r_count + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_word = (w_count_inc == DEPTH);

`ifdef INSTR_ENC_NOP_PAD_EN
  logic w_is_ctrl;
  assign w_is_ctrl  = (r_cls == CLS_B) || (r_cls == CLS_JAL) || (r_cls == CLS_JALR);
  assign w_wr_state = (r_state == ST_WR) || (r_state == ST_PAD);
`else
  assign w_wr_state = (r_state == ST_WR);
`endif

  instr_encoder_imm_packer u_imm_packer (
    .i_cls      (r_cls),
    .i_funct3   (r_funct3),
    .i_imm      (r_imm),
    .o_imm_bits (w_imm_bits),
    .o_range_ok (w_range_ok)
  );

  always_comb begin
    w_enc_word      = {w_imm_bits, 7'b0};
    w_enc_word[6:0] = opcode_of(r_cls);
    if (uses_rd(r_cls))  w_enc_word[11:7]  = r_rd;
    if (uses_rs1(r_cls)) w_enc_word[19:15] = r_rs1;
    if (uses_rs2(r_cls)) w_enc_word[24:20] = r_rs2;
    case (r_cls)
      CLS_R, CLS_I, CLS_B: w_enc_word[14:12] = r_funct3;
      CLS_LW, CLS_SW:      w_enc_word[14:12] = 3'b010;
      CLS_JALR:            w_enc_word[14:12] = 3'b000;
      default:             ;
    endcase
    // instr[30] selects SUB/SRA and SRAI; for every other I-type it is an immediate bit.
    if (r_cls == CLS_R || (r_cls == CLS_I && r_funct3 == 3'b101)) begin
      w_enc_word[30] = r_funct7b5;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_ENC;
      ST_ENC:  w_next = w_range_ok ? ST_WR : ST_IDLE;
      ST_WR: begin
        if (w_last_word) w_next = ST_FULL;
`ifdef INSTR_ENC_NOP_PAD_EN
        else if (w_is_ctrl) w_next = ST_PAD;
`endif
        else w_next = ST_IDLE;
      end
`ifdef INSTR_ENC_NOP_PAD_EN
      ST_PAD:  w_next = w_last_word ? ST_FULL : ST_IDLE;
`endif
      ST_FULL: w_next = ST_FULL;
      default: w_next = ST_IDLE;
    endcase
    if (clear) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rst_done <= 1'b0;
      r_cls      <= CLS_R;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_word     <= '0;
      r_addr     <= START_ADDR;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rst_done <= 1'b1;
      if (clear) begin
        r_addr  <= START_ADDR;
        r_count <= '0;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_cls      <= cls_e'(in_class);
              r_funct3   <= funct3;
              r_funct7b5 <= funct7b5;
              r_rd       <= rd;
              r_rs1      <= rs1;
              r_rs2      <= rs2;
              r_imm      <= imm;
            end
          end
          ST_ENC: begin
            if (w_range_ok) r_word <= w_enc_word;
            else            r_err  <= 1'b1;
          end
          ST_WR: begin
            r_count <= w_count_inc;
            if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
`ifdef INSTR_ENC_NOP_PAD_EN
            if (w_is_ctrl && !w_last_word) r_word <= NOP_WORD;
`endif
          end
`ifdef INSTR_ENC_NOP_PAD_EN
          ST_PAD: begin
            r_count <= w_count_inc;
            if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // A clear arriving during a write cycle cancels the strobe for that cycle.
  assign mem_we    = w_wr_state && !clear;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_word;
  assign count     = r_count;
  assign full      = w_full;
  assign err       = r_err;
  assign in_ready  = w_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written corner
// sequences and randomized bundles scored against a format-level reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef INSTR_ENC_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct packed {
    bundle_t     b;
    logic        ok;
    logic [31:0] w;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_class = '0;
  logic [2:0]        funct3 = '0;
  logic              funct7b5 = 1'b0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [31:0]       imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  state_e            dbg_state;

  instr_encoder #(.ADDR_W(ADDR_W), .START_ADDR(6'd0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .funct3(funct3), .funct7b5(funct7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [ADDR_W+31:0] exp_q[$];
  int m_addr = 0;
  int m_count = 0;
  bit m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      logic [ADDR_W+31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                   mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void ref_encode(input bundle_t b, output bit ok, output logic [31:0] w);
    longint s;
    logic [31:0] u;
    u  = b.imm;
    s  = longint'($signed(b.imm));
    ok = 1'b1;
    w  = '0;
    case (b.cls)
      3'd0: w = {1'b0, b.f7, 5'b0, b.rs2, b.rs1, b.f3, b.rd, 7'b0110011};
      3'd1: begin
        if (b.f3 == 3'd1 || b.f3 == 3'd5) begin
          ok = (s >= 0) && (s <= 31);
          w  = {1'b0, ((b.f3 == 3'd5) ? b.f7 : 1'b0), 5'b0, u[4:0], b.rs1, b.f3, b.rd, 7'b0010011};
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w  = {u[11:0], b.rs1, b.f3, b.rd, 7'b0010011};
        end
      end
      3'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {u[11:0], b.rs1, 3'b010, b.rd, 7'b0000011};
      end
      3'd3: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {u[11:5], b.rs2, b.rs1, 3'b010, u[4:0], 7'b0100011};
      end
      3'd4: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w  = {u[12], u[10:5], b.rs2, b.rs1, b.f3, u[4:1], u[11], 7'b1100011};
      end
      3'd5: begin
        ok = (s >= -(64'sd1 << 20)) && (s <= (64'sd1 << 20) - 2) && (s % 2 == 0);
        w  = {u[20], u[10:1], u[11], u[19:12], b.rd, 7'b1101111};
      end
      3'd6: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {u[11:0], b.rs1, 3'b000, b.rd, 7'b1100111};
      end
      default: begin
        ok = (u[11:0] == 12'h000);
        w  = {u[31:12], b.rd, 7'b0110111};
      end
    endcase
  endfunction

  task automatic model_write(input logic [31:0] w);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(m_addr);
    exp_q.push_back({a, w});
    m_count++;
    if (m_addr < DEPTH - 1) m_addr++;
  endtask

  task automatic model_result(input bit ok, input logic [31:0] w, input logic [2:0] cls);
    if (!ok) begin
      m_err = 1'b1;
    end else begin
      model_write(w);
      if (PAD_EN && (cls == 3'd4 || cls == 3'd5 || cls == 3'd6) && m_count < DEPTH)
        model_write(32'h0000_0013);
    end
  endtask

  task automatic model_reset();
    m_addr  = 0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_fields(input bundle_t b);
    in_class = b.cls; funct3 = b.f3; funct7b5 = b.f7;
    rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm = b.imm;
  endtask

  task automatic send(input bundle_t b, input int budget, output bit acc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    drive_fields(b);
    while (in_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    acc = (in_ready === 1'b1);
    if (acc) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic run_vec(input bundle_t b, input bit ok, input logic [31:0] w, input string name);
    bit acc;
    send(b, 50, acc);
    chk({name, "_accept"}, 64'(acc), 64'd1);
    if (acc) model_result(ok, w, b.cls);
    repeat (5) @(negedge clk);
    chk({name, "_err"}, 64'(err), 64'(m_err));
    chk({name, "_count"}, 64'(count), 64'(m_count));
  endtask

  function automatic bundle_t mkb(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                                  input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [31:0] im);
    bundle_t b;
    b.cls = c; b.f3 = f3; b.f7 = f7; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.imm = im;
    return b;
  endfunction

  function automatic vec_t mkv(input bundle_t b, input logic ok, input logic [31:0] w);
    vec_t v;
    v.b = b; v.ok = ok; v.w = w;
    return v;
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: r = 32'($signed($urandom_range(0, 4095)) - 2048);
      1: begin
        case ($urandom_range(0, 9))
          0: r = 32'd2047;
          1: r = 32'd2048;
          2: r = -32'sd2048;
          3: r = -32'sd2049;
          4: r = 32'd4094;
          5: r = 32'd4095;
          6: r = -32'sd4096;
          7: r = 32'h000F_FFFE;
          8: r = 32'h0010_0000;
          default: r = 32'hFFF0_0000;
        endcase
      end
      2: r = $urandom() & 32'hFFFF_F000;
      3: r = 32'($urandom_range(0, 40));
      default: r = 32'($signed($urandom_range(0, 4095)) * 2 - 4096);
    endcase
    return r;
  endfunction

  vec_t tbl[15];

  initial begin
    bundle_t b;
    bit acc;
    bit ok;
    logic [31:0] w;

    tbl[0]  = mkv(mkb(3'd3, 3'd2, 1'b0, 5'd9, 5'd2, 5'd5, 32'd8),           1'b1, 32'h0051_2423);
    tbl[1]  = mkv(mkb(3'd7, 3'd0, 1'b0, 5'd5, 5'd3, 5'd4, 32'h1234_5000),   1'b1, 32'h1234_52B7);
    tbl[2]  = mkv(mkb(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4),         1'b1, 32'hFE20_8EE3);
    tbl[3]  = mkv(mkb(3'd1, 3'd0, 1'b1, 5'd1, 5'd0, 5'd7, -32'sd1),         1'b1, 32'hFFF0_0093);
    tbl[4]  = mkv(mkb(3'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3),           1'b1, 32'h4033_5293);
    tbl[5]  = mkv(mkb(3'd5, 3'd7, 1'b1, 5'd1, 5'd4, 5'd4, 32'd8),           1'b1, 32'h0080_00EF);
    tbl[6]  = mkv(mkb(3'd6, 3'd3, 1'b0, 5'd0, 5'd1, 5'd9, 32'd0),           1'b1, 32'h0000_8067);
    tbl[7]  = mkv(mkb(3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd3, 32'd4),           1'b1, 32'h0041_2283);
    tbl[8]  = mkv(mkb(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048),        1'b0, 32'h0);
    tbl[9]  = mkv(mkb(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3),           1'b0, 32'h0);
    tbl[10] = mkv(mkb(3'd1, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32),          1'b0, 32'h0);
    tbl[11] = mkv(mkb(3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001),   1'b0, 32'h0);
    tbl[12] = mkv(mkb(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047),        1'b1, 32'h7FF0_0093);
    tbl[13] = mkv(mkb(3'd4, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, -32'sd4096),      1'b1, 32'h8000_0063);
    tbl[14] = mkv(mkb(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF),   1'b1, 32'h4031_00B3);

    // ---- reset state ----
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_ready_high", 64'(in_ready), 64'd1);

    // ---- add x3,x1,x2: write strobe two edges after acceptance ----
    b = mkb(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(b, 50, acc);
    chk("add_accept", 64'(acc), 64'd1);
    model_result(1'b1, 32'h0020_81B3, 3'd0);
    @(negedge clk);
    chk("add_we_enc_cycle", 64'(mem_we), 64'd0);
    @(negedge clk);
    chk("add_we_wr_cycle", 64'(mem_we), 64'd1);
    chk("add_addr", 64'(mem_addr), 64'd0);
    chk("add_wdata", 64'(mem_wdata), 64'h0020_81B3);
    repeat (3) @(negedge clk);
    chk("add_count", 64'(count), 64'd1);

    // ---- directed vector table ----
    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i].b, tbl[i].ok, tbl[i].w, $sformatf("vec%0d", i));
    end

    // ---- randomized bundles against the reference model ----
    do_clear();
    @(negedge clk);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_err", 64'(err), 64'd0);
    for (int i = 0; i < 20; i++) begin
      b.cls = 3'($urandom_range(0, 7));
      b.f3  = 3'($urandom_range(0, 7));
      b.f7  = 1'($urandom_range(0, 1));
      b.rd  = 5'($urandom_range(0, 31));
      b.rs1 = 5'($urandom_range(0, 31));
      b.rs2 = 5'($urandom_range(0, 31));
      b.imm = rand_imm();
      ref_encode(b, ok, w);
      run_vec(b, ok, w, $sformatf("rnd%0d", i));
    end

    // ---- reset during a write cycle ----
    b = mkb(3'd0, 3'd0, 1'b0, 5'd4, 5'd5, 5'd6, 32'd0);
    send(b, 50, acc);
    chk("rstwr_accept", 64'(acc), 64'd1);
    chk("rstwr_enc_state", 64'(dbg_state), 64'(ST_ENC));
    @(posedge clk);
    #1;
    chk("rstwr_we_before", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstwr_we", 64'(mem_we), 64'd0);
    chk("rstwr_addr", 64'(mem_addr), 64'd0);
    chk("rstwr_wdata", 64'(mem_wdata), 64'd0);
    chk("rstwr_count", 64'(count), 64'd0);
    chk("rstwr_err", 64'(err), 64'd0);
    chk("rstwr_full", 64'(full), 64'd0);
    chk("rstwr_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstwr_ready_hold", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rstwr_ready_back", 64'(in_ready), 64'd1);

    // ---- clear concurrent with in_valid: bundle refused ----
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    drive_fields(mkb(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0));
    #1;
    chk("clear_vs_valid_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("clear_vs_valid_count", 64'(count), 64'd0);
    chk("clear_vs_valid_state", 64'(dbg_state), 64'(ST_IDLE));

    // ---- clear during a write cycle aborts it ----
    send(mkb(3'd0, 3'd0, 1'b0, 5'd2, 5'd2, 5'd2, 32'd0), 50, acc);
    chk("clrwr_accept", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    #1;
    chk("clrwr_we", 64'(mem_we), 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("clrwr_count", 64'(count), 64'd0);
    chk("clrwr_addr", 64'(mem_addr), 64'd0);

    // ---- fill to capacity back-to-back, then hold off and clear ----
    for (int i = 0; i < DEPTH; i++) begin
      b = mkb(3'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 32'd0);
      send(b, 50, acc);
      chk($sformatf("fill%0d_accept", i), 64'(acc), 64'd1);
      ref_encode(b, ok, w);
      if (acc) model_result(ok, w, b.cls);
    end
    repeat (5) @(negedge clk);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(in_ready), 64'd0);
    chk("fill_count", 64'(count), 64'(m_count));
    send(mkb(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0), 12, acc);
    chk("fill_overflow_held", 64'(acc), 64'd0);
    do_clear();
    @(negedge clk);
    chk("fill_clear_count", 64'(count), 64'd0);
    chk("fill_clear_addr", 64'(mem_addr), 64'd0);
    chk("fill_clear_ready", 64'(in_ready), 64'd1);
    chk("fill_clear_full", 64'(full), 64'd0);

    repeat (4) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
